// File: rtl/lfsr_rand_pkg.sv
// Shared types and helpers for the LFSR random source: FSM states, the
// Fibonacci step function and a table of maximal-length feedback masks.
package lfsr_rand_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_RESP   = 2'd2
  } fsm_state_e;

  // Maximal-length masks: bit i set taps state[i] into the feedback.
  localparam logic [3:0]  TAPS_W4  = 4'h3;
  localparam logic [4:0]  TAPS_W5  = 5'h05;
  localparam logic [5:0]  TAPS_W6  = 6'h03;
  localparam logic [6:0]  TAPS_W7  = 7'h03;
  localparam logic [7:0]  TAPS_W8  = 8'h1D;
  localparam logic [8:0]  TAPS_W9  = 9'h011;
  localparam logic [9:0]  TAPS_W10 = 10'h009;
  localparam logic [10:0] TAPS_W11 = 11'h005;
  localparam logic [11:0] TAPS_W12 = 12'h053;
  localparam logic [12:0] TAPS_W13 = 13'h001B;
  localparam logic [13:0] TAPS_W14 = 14'h0443;
  localparam logic [14:0] TAPS_W15 = 15'h0003;
  localparam logic [15:0] TAPS_W16 = 16'h100B;

  // One step: shift right, feedback (parity of tapped bits) enters the MSB.
  // Expects bits at and above 'width' of state to be zero.
  function automatic logic [31:0] next_lfsr(input logic [31:0] state,
                                            input logic [31:0] mask,
                                            input int unsigned width);
    logic        fb;
    logic [31:0] nxt;
    fb  = ^(state & mask);
    nxt = (state >> 1) | (32'(fb) << (width - 1));
    return nxt;
  endfunction

endpackage

// File: rtl/lfsr_rand_gen_core.sv
// LFSR register with seed-load over step priority and a guard that keeps a
// zero seed from locking the register up.
module lfsr_core
  import lfsr_rand_pkg::*;
#(
  parameter int unsigned          WIDTH    = 8,
  parameter logic [WIDTH-1:0]     TAP_MASK = WIDTH'(8'h1D),
  parameter logic [WIDTH-1:0]     SEED     = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (seed_load) begin
      state_d = (seed_in == '0) ? WIDTH'(1) : seed_in;
    end else if (step) begin
      state_d = WIDTH'(next_lfsr(32'(state_q), 32'(TAP_MASK), WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_rand_gen.sv
// Range-limited random source: an LFSR plus a request/response FSM that
// rejection-samples the low OUT_W bits against the requested bound.
module lfsr_rand_gen
  import lfsr_rand_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      OUT_W     = 6,
  parameter logic [WIDTH-1:0] TAP_MASK  = WIDTH'(8'h1D),
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
  parameter int unsigned      MAX_TRIES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OUT_W-1:0] req_limit,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [OUT_W-1:0] rsp_data,
  output logic             rsp_fallback,
  output logic [WIDTH-1:0] lfsr_state
);

  localparam int unsigned     TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  fsm_state_e       fsm_q, fsm_d;
  logic [OUT_W:0]   limit_q, limit_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [OUT_W-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_fallback_q, rsp_fallback_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             req_ready_q, req_ready_d;

  logic [OUT_W-1:0] cand;
  logic             cand_ok;
  logic             step;

  // The search consumes one LFSR step per attempt regardless of en.
  assign step = en | (fsm_q == ST_SEARCH);

  lfsr_core #(
    .WIDTH    (WIDTH),
    .TAP_MASK (TAP_MASK),
    .SEED     (SEED)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .step      (step),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .state     (lfsr_state)
  );

  assign cand    = lfsr_state[OUT_W-1:0];
  assign cand_ok = {1'b0, cand} < limit_q;

  always_comb begin
    fsm_d          = fsm_q;
    limit_d        = limit_q;
    tries_d        = tries_q;
    rsp_data_d     = rsp_data_q;
    rsp_fallback_d = rsp_fallback_q;
    rsp_valid_d    = rsp_valid_q;
    req_ready_d    = req_ready_q;
    unique case (fsm_q)
      ST_IDLE: begin
        if (req_valid) begin
          // A zero limit widens to 2^OUT_W so every candidate passes.
          limit_d     = (req_limit == '0) ? {1'b1, {OUT_W{1'b0}}} : {1'b0, req_limit};
          tries_d     = '0;
          fsm_d       = ST_SEARCH;
          req_ready_d = 1'b0;
        end
      end
      ST_SEARCH: begin
        if (cand_ok) begin
          rsp_data_d     = cand;
          rsp_fallback_d = 1'b0;
          rsp_valid_d    = 1'b1;
          fsm_d          = ST_RESP;
        end else if (tries_q == LAST_TRY) begin
          rsp_data_d     = '0;
          rsp_fallback_d = 1'b1;
          rsp_valid_d    = 1'b1;
          fsm_d          = ST_RESP;
        end else begin
          tries_d = tries_q + TRY_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          fsm_d       = ST_IDLE;
        end
      end
      default: begin
        fsm_d       = ST_IDLE;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q          <= ST_IDLE;
      limit_q        <= '0;
      tries_q        <= '0;
      rsp_data_q     <= '0;
      rsp_fallback_q <= 1'b0;
      rsp_valid_q    <= 1'b0;
      req_ready_q    <= 1'b1;
    end else begin
      fsm_q          <= fsm_d;
      limit_q        <= limit_d;
      tries_q        <= tries_d;
      rsp_data_q     <= rsp_data_d;
      rsp_fallback_q <= rsp_fallback_d;
      rsp_valid_q    <= rsp_valid_d;
      req_ready_q    <= req_ready_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_fallback = rsp_fallback_q;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Scoreboard bench for lfsr_rand_gen: randomized traffic against an arithmetic
// reference model, plus a 4-bit instance for sequence and fallback cases.
module tb_lfsr_rand_gen;

  localparam int unsigned W     = 8;
  localparam int unsigned OW    = 6;
  localparam int unsigned MT    = 16;
  localparam int unsigned MASK  = 'h1D;
  localparam int unsigned SEEDV = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          en = 1'b0, seed_load = 1'b0;
  logic [W-1:0]  seed_in = '0;
  logic          req_valid = 1'b0, req_ready;
  logic [OW-1:0] req_limit = '0;
  logic          rsp_valid, rsp_ready = 1'b1;
  logic [OW-1:0] rsp_data;
  logic          rsp_fallback;
  logic [W-1:0]  lfsr_state;

  logic          en_b = 1'b0, req_valid_b = 1'b0, req_ready_b;
  logic [3:0]    req_limit_b = 4'd1;
  logic          rsp_valid_b, rsp_fallback_b;
  logic [3:0]    rsp_data_b, lfsr_b;

  lfsr_rand_gen dut (
    .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_limit(req_limit),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_fallback(rsp_fallback), .lfsr_state(lfsr_state)
  );

  lfsr_rand_gen #(.WIDTH(4), .OUT_W(4), .TAP_MASK(4'h3), .SEED(4'd1), .MAX_TRIES(4)) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .seed_load(1'b0), .seed_in(4'd0),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_limit(req_limit_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(1'b1), .rsp_data(rsp_data_b),
    .rsp_fallback(rsp_fallback_b), .lfsr_state(lfsr_b)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int unsigned data;
    bit          fb;
    int unsigned lim;
    int          vcyc;
  } exp_t;
  exp_t sb[$];

  int unsigned m_lfsr = SEEDV;
  bit          m_busy = 1'b0;
  int unsigned m_left = 0;
  bit          last_acc = 1'b0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Parity of the tapped bits enters at the top, everything else halves.
  function automatic int unsigned mnext(input int unsigned s, input int unsigned mask,
                                        input int unsigned w);
    int unsigned ones = 0;
    for (int unsigned i = 0; i < w; i++)
      if ((((s >> i) & 1) == 1) && (((mask >> i) & 1) == 1)) ones++;
    return (s / 2) + ((ones % 2) << (w - 1));
  endfunction

  task automatic tick();
    bit          pre_resp, acc, stepping, fb;
    int unsigned s, lim, data, lat;
    pre_resp = m_busy && (m_left == 0);
    acc      = !m_busy && req_valid && !reset;
    lim      = (req_limit == 0) ? (1 << OW) : int'(req_limit);
    @(posedge clk);
    #1;
    last_acc = 1'b0;
    if (reset) begin
      m_lfsr = SEEDV; m_busy = 1'b0; m_left = 0;
      sb.delete();
    end else begin
      stepping = en || (m_busy && m_left > 0);
      if (seed_load) m_lfsr = (seed_in == 0) ? 1 : int'(seed_in);
      else if (stepping) m_lfsr = mnext(m_lfsr, MASK, W);
      if (m_busy && m_left > 0) m_left--;
      if (pre_resp && rsp_ready) m_busy = 1'b0;
      if (acc) begin
        s = m_lfsr; data = 0; fb = 1'b1; lat = MT;
        for (int unsigned t = 1; t <= MT; t++) begin
          if ((s % (1 << OW)) < lim) begin
            data = s % (1 << OW); fb = 1'b0; lat = t;
            break;
          end
          s = mnext(s, MASK, W);
        end
        m_busy = 1'b1; m_left = lat; last_acc = 1'b1;
        sb.push_back('{data: data, fb: fb, lim: lim, vcyc: cyc + int'(lat)});
      end
    end
    chk("lfsr_state", lfsr_state, m_lfsr);
    chk("req_ready", req_ready, !m_busy);
    chk("rsp_valid", rsp_valid, m_busy && (m_left == 0));
  endtask

  bit prev_valid = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL stray_rsp actual=valid required=no_response (cycle %0d)", cyc);
        end else begin
          if (!prev_valid) chk("rsp_latency_cycle", cyc, sb[0].vcyc);
          chk("rsp_data", rsp_data, sb[0].data);
          chk("rsp_fallback", rsp_fallback, sb[0].fb);
          chk("rsp_in_range", rsp_data < sb[0].lim, 1);
          if (rsp_ready) void'(sb.pop_front());
        end
      end
      prev_valid = rsp_valid && !reset;
    end
  end

  initial begin
    int          first[int];
    int          first_b[int];
    int          period, period_b, n, guard;
    bit          zero_seen;
    int unsigned seq_b[6];
    int unsigned lims[3];
    int unsigned s0;

    seq_b = '{1, 8, 4, 2, 9, 12};
    lims  = '{1, 10, 0};

    // Reset state
    tick(); tick();
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_fallback", rsp_fallback, 0);
    chk("reset_b_state", lfsr_b, 1);
    reset = 1'b0;

    // Free-running period on both instances
    en = 1'b1; en_b = 1'b1;
    period = 0; period_b = 0; zero_seen = 1'b0;
    first[int'(lfsr_state)] = 0;
    first_b[int'(lfsr_b)] = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i < 6) chk("b_sequence", lfsr_b, seq_b[i]);
      if (lfsr_state == 0 || lfsr_b == 0) zero_seen = 1'b1;
      if (first.exists(int'(lfsr_state))) begin
        if (period == 0) period = i - first[int'(lfsr_state)];
      end else first[int'(lfsr_state)] = i;
      if (first_b.exists(int'(lfsr_b))) begin
        if (period_b == 0) period_b = i - first_b[int'(lfsr_b)];
      end else first_b[int'(lfsr_b)] = i;
    end
    chk("distinct_states_8", first.num(), 255);
    chk("period_8", period, 255);
    chk("distinct_states_4", first_b.num(), 15);
    chk("period_4", period_b, 15);
    chk("never_zero", zero_seen, 0);
    en_b = 1'b0;

    en = 1'b0; seed_load = 1'b1; seed_in = '0;
    tick();
    chk("seed_zero_guard", lfsr_state, 1);
    en = 1'b1; seed_in = 8'hA5;
    tick();
    chk("seed_over_step", lfsr_state, 'hA5);
    seed_load = 1'b0; en = 1'b0;

    // Fallback on the 4-bit instance: limit 1 can never be met
    chk("b_req_ready_idle", req_ready_b, 1);
    req_valid_b = 1'b1; req_limit_b = 4'd1;
    tick();
    s0 = lfsr_b;
    req_valid_b = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("b_rsp_valid_timing", rsp_valid_b, k == 4);
    end
    chk("b_rsp_data", rsp_data_b, 0);
    chk("b_rsp_fallback", rsp_fallback_b, 1);
    chk("b_lfsr_4_steps", lfsr_b, mnext(mnext(mnext(mnext(s0, 3, 4), 3, 4), 3, 4), 3, 4));
    tick();
    chk("b_back_to_idle", req_ready_b, 1);

    // Randomized requests per limit
    foreach (lims[li]) begin
      n = 0; guard = 0;
      req_limit = OW'(lims[li]);
      while (n < 1000 && guard < 40000) begin
        en        = ($urandom % 2) == 1;
        req_valid = ($urandom % 4) != 0;
        rsp_ready = ($urandom % 3) != 0;
        seed_load = (($urandom % 64) == 0) && !(m_busy && m_left > 0);
        seed_in   = W'($urandom % 4);
        if (($urandom % 2) == 1) seed_in = W'($urandom);
        tick();
        if (last_acc) n++;
        guard++;
      end
      chk("random_requests_done", n, 1000);
      req_valid = 1'b0; rsp_ready = 1'b1; seed_load = 1'b0;
      for (int i = 0; i < 40; i++) tick();
      chk("scoreboard_drained", sb.size(), 0);
    end

    // Backpressure with a request held pending
    en = 1'b0; rsp_ready = 1'b0; req_valid = 1'b1; req_limit = '0;
    for (int i = 0; i < 7; i++) tick();
    chk("bp_valid_held", rsp_valid, 1);
    rsp_ready = 1'b1;
    tick(); tick();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Reset during SEARCH
    req_valid = 1'b1; req_limit = OW'(1);
    tick();
    req_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("rst_search_valid", rsp_valid, 0);
    chk("rst_search_ready", req_ready, 1);
    chk("rst_search_lfsr", lfsr_state, SEEDV);
    reset = 1'b0;
    for (int i = 0; i < 25; i++) tick();

    // Reset during RESP
    rsp_ready = 1'b0; req_valid = 1'b1; req_limit = '0;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    chk("resp_before_reset", rsp_valid, 1);
    reset = 1'b1;
    tick();
    chk("rst_resp_valid", rsp_valid, 0);
    chk("rst_resp_ready", req_ready, 1);
    chk("rst_resp_lfsr", lfsr_state, SEEDV);
    reset = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("final_scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_rand_gen.md
Name: lfsr_rand_gen

Overview:
Parametrised Fibonacci LFSR random source for game logic such as food placement and spawn positions. Width, taps and seed are parameters. Supports runtime reseeding and free-running entropy stepping. Answers range-limited requests over a valid/ready handshake, using rejection sampling with a bounded retry count. Sits between the game FSM (requester) and the board/placement logic.

Parameters:
WIDTH, 8, LFSR state width (3..32)
OUT_W, 6, result width; OUT_W <= WIDTH
TAP_MASK, 8'h1D, feedback taps; bit i set -> state[i] XORed into feedback. Default gives x^8+x^4+x^3+x^2+1, maximal
SEED, 1, reset state; must be nonzero
MAX_TRIES, 16, rejection attempts before fallback (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
en  in  1  free-run step enable (1 step per cycle)
seed_load  in  1  load seed_in into LFSR this cycle
seed_in  in  WIDTH  seed value
req_valid  in  1  range request valid
req_ready  out  1  block can accept request
req_limit  in  OUT_W  exclusive upper bound; 0 means full range 2^OUT_W
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_data  out  OUT_W  result, in [0, limit-1]
rsp_fallback  out  1  result is fallback 0 (retries exhausted)
lfsr_state  out  WIDTH  current LFSR state

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. Reset overrides everything.
- Reset values: LFSR = SEED; FSM = IDLE; rsp_valid = 0; rsp_data = 0; rsp_fallback = 0; try counter = 0; req_ready = 1 in the cycle after reset.
- Step rule: state <= {fb, state[WIDTH-1:1]}, where fb = XOR of state[i] over all i with TAP_MASK[i] = 1.
- LFSR update priority per cycle: seed_load > step > hold.
  - seed_load: state <= seed_in. If seed_in == 0, state <= 1 (lockup guard).
  - Step occurs when en = 1 or FSM == SEARCH.
  - A seed_load during SEARCH replaces the step for that cycle. The search continues.
- FSM states: IDLE, SEARCH, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch limit_q (0 is treated as 2^OUT_W, i.e. always accept), clear tries, go to SEARCH.
- SEARCH (req_ready = 0):
  - cand = state[OUT_W-1:0], sampled before this cycle's step.
  - If cand < limit_q: rsp_data <= cand, rsp_fallback <= 0, go to RESP.
  - Else if tries == MAX_TRIES-1: rsp_data <= 0, rsp_fallback <= 1, go to RESP.
  - Else tries++ and stay in SEARCH.
- RESP:
  - rsp_valid = 1; rsp_data and rsp_fallback held stable.
  - On rsp_ready: go to IDLE.
  - en-driven stepping continues in RESP.
- Latency: accept at edge N gives rsp_valid high after edge N+1 when the first candidate is accepted. Worst case is N+MAX_TRIES.
- Throughput: one request per 3 cycles minimum. No request/response overlap, no same-cycle re-accept.
- Reset mid-operation: any in-flight request is dropped with no response. rsp_valid falls at the reset edge.
- Width rules: all comparisons unsigned. limit_q is held in OUT_W+1 bits.

Decomposition:
- Package lfsr_rand_pkg:
  - FSM state enum (IDLE, SEARCH, RESP).
  - Function next_lfsr(state, mask) implementing the step rule.
  - Constants of recommended maximal tap masks for widths 4..16 (4'h3, 8'h1D, ...).
- Sub-module lfsr_core holds the register, seed/step priority and zero-seed guard. It exposes state.
- lfsr_rand_gen holds the FSM, rejection logic and handshake.

Test Plan:
1. WIDTH=4, TAP_MASK=4'h3, SEED=1, en=1 after reset -> lfsr_state sequence 1,8,4,2,9,12,...; all 15 nonzero states visited; period exactly 15.
2. Defaults, en=1 for 300 cycles -> 255 distinct nonzero states, period 255, never 0. Then seed_load with seed_in=0 -> next lfsr_state = 1. seed_load with seed_in=8'hA5 concurrent with en=1 -> next state = A5, no step.
3. Defaults, requests with limit=1, 10, 0 (full range), 1000 trials each -> rsp_data always < limit (64 for limit 0); rsp_fallback = 0 unless retries exhausted; first accepted response arrives 1 cycle after accept.
4. WIDTH=4, OUT_W=4, TAP_MASK=4'h3, MAX_TRIES=4, limit=1 -> cand is never 0 -> rsp_valid 4 cycles after accept, rsp_data=0, rsp_fallback=1, LFSR advanced 4 steps.
5. Backpressure: rsp_ready held low 5 cycles -> rsp_valid, rsp_data and rsp_fallback stable; req_ready=0 throughout; IDLE only after the rsp_ready cycle; a req_valid held high meanwhile is accepted only after that.
6. Assert reset while in SEARCH and again while in RESP -> next cycle: rsp_valid=0, req_ready=1, lfsr_state=SEED, no stray response afterwards.
